// File: rtl/psg_arb_pkg.sv
// Shared types for the PSG register-write arbiter: FSM encoding, grant index and counter widths.
// PSG_ARB_LOCK_EN (optional) enables burst locking; LOCK_CNT_W sizes its idle timeout counter.
package psg_arb_pkg;
   localparam int STATE_W    = 2;
   localparam int GRANT_W    = 3;
   localparam int GAP_CNT_W  = 8;
   localparam int LOCK_CNT_W = 16;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2
   } arb_state_t;
endpackage

// File: rtl/psg_arb_rr_pick.sv
// Rotate-priority picker: first set bit of (req & mask) scanning upward from start, wrapping at NUM_REQ.
// Purely combinational, zero latency; no backpressure of its own.
module psg_arb_rr_pick
   import psg_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [GRANT_W-1:0] start,
   output logic [NUM_REQ-1:0] sel_oh,
   output logic [GRANT_W-1:0] sel_idx,
   output logic               sel_any
);
   logic [NUM_REQ-1:0] eff;
   logic [NUM_REQ-1:0] rot;
   logic [NUM_REQ-1:0] rot_unused_hi;
   int                 pick;

   assign eff = req & mask;
   // Doubling the vector turns the wrap-around scan into a plain right shift.
   assign {rot_unused_hi, rot} = {eff, eff} >> start;

   always_comb begin
      sel_any = 1'b0;
      pick    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sel_any = 1'b1;
            pick    = k;
         end
      end
      pick = pick + int'(start);
      if (pick >= NUM_REQ) pick = pick - NUM_REQ;
      sel_idx = GRANT_W'(pick);
      sel_oh  = sel_any ? (NUM_REQ'(1) << sel_idx) : '0;
   end
endmodule

// File: rtl/psg_reg_arbiter.sv
// Round-robin arbiter onto the PSG write port; accept in IDLE, psg_we next cycle until psg_ack, then GAP_CYCLES idle.
// req_ready pulses only in IDLE; requesters hold until accepted. Define PSG_ARB_LOCK_EN for owner burst locking.
module psg_reg_arbiter
   import psg_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int GAP_CYCLES   = 2,
   parameter int LOCK_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      psg_we,
   output logic [ADDR_W-1:0]         psg_addr,
   output logic [DATA_W-1:0]         psg_data,
   input  logic                      psg_ack,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      busy
);
   localparam logic [GRANT_W-1:0]   LAST_IDX = GRANT_W'(NUM_REQ - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   arb_state_t           state, state_nxt;
   logic [GRANT_W-1:0]   last_grant, start_idx, sel_idx;
   logic [NUM_REQ-1:0]   sel_oh, lock_mask;
   logic                 sel_any, accept;
   logic [GAP_CNT_W-1:0] gap_cnt;
   logic [ADDR_W-1:0]    addr_mux;
   logic [DATA_W-1:0]    data_mux;

   assign start_idx = (last_grant >= LAST_IDX) ? '0 : last_grant + 1'b1;
   assign accept    = (state == IDLE) && sel_any;

   psg_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (req_valid),
      .mask    (lock_mask),
      .start   (start_idx),
      .sel_oh  (sel_oh),
      .sel_idx (sel_idx),
      .sel_any (sel_any)
   );

   always_comb begin
      addr_mux = '0;
      data_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_mux = addr_mux | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{sel_oh[i]}});
         data_mux = data_mux | (req_data[i*DATA_W +: DATA_W] & {DATA_W{sel_oh[i]}});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_any) state_nxt = WRITE;
         WRITE:   if (psg_ack) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
         GAP:     if (gap_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobe and ready decode straight from state so reset drops them without waiting for a clock.
   always_comb begin
      req_ready = '0;
      if (state == IDLE) req_ready = sel_oh;
      psg_we = (state == WRITE);
      busy   = (state != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psg_addr   <= '0;
         psg_data   <= '0;
         grant_id   <= '0;
         last_grant <= LAST_IDX;
         gap_cnt    <= '0;
      end else begin
         if (accept) begin
            psg_addr   <= addr_mux;
            psg_data   <= data_mux;
            grant_id   <= sel_idx;
            last_grant <= sel_idx;
         end
         if (state == WRITE && psg_ack)            gap_cnt <= GAP_LOAD;
         else if (state == GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
      end
   end

`ifdef PSG_ARB_LOCK_EN
   logic                  lock_on;
   logic [GRANT_W-1:0]    lock_owner;
   logic [LOCK_CNT_W-1:0] lock_cnt;
   logic [NUM_REQ-1:0]    owner_oh;
   logic                  owner_valid;

   assign owner_oh    = NUM_REQ'(1) << lock_owner;
   assign owner_valid = |(req_valid & owner_oh);
   assign lock_mask   = lock_on ? owner_oh : '1;

   // Timeout counts only IDLE cycles with the owner silent; any owner request restarts it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_on    <= 1'b0;
         lock_owner <= '0;
         lock_cnt   <= '0;
      end else if (accept) begin
         lock_on    <= |(req_lock & sel_oh);
         lock_owner <= sel_idx;
         lock_cnt   <= '0;
      end else if (state == IDLE && lock_on && !owner_valid) begin
         if (lock_cnt == LOCK_CNT_W'(LOCK_TIMEOUT - 1)) begin
            lock_on  <= 1'b0;
            lock_cnt <= '0;
         end else begin
            lock_cnt <= lock_cnt + 1'b1;
         end
      end else if (owner_valid) begin
         lock_cnt <= '0;
      end
   end
`else
   localparam int unused_lock_timeout = LOCK_TIMEOUT;
   localparam int unused_lock_cnt_w   = LOCK_CNT_W;
   logic unused_lock;

   assign unused_lock = ^req_lock;
   assign lock_mask   = '1;
`endif
endmodule
